// File: rtl/core_pkg.sv
// core_pkg: core-wide architectural widths shared by pipeline blocks
package core_pkg;
  localparam int RF_ADDR_WIDTH  = 5;
  localparam int CSR_ADDR_WIDTH = 12;
endpackage

// File: rtl/ctrl_scoreboard_pkg.sv
// ctrl_scoreboard_pkg: scoreboard defaults and pending-CSR slot type
package ctrl_scoreboard_pkg;
  localparam int DEF_NB_RS        = 2;
  localparam int DEF_MAX_INFLIGHT = 3;
  localparam int DEF_CSR_SLOTS    = 2;
  typedef struct packed {
    logic                               valid;
    logic [core_pkg::CSR_ADDR_WIDTH-1:0] addr;
  } csr_slot_t;
endpackage

// File: rtl/csr_pending_cam.sv
// csr_pending_cam: pending CSR-write table with lookup, lowest-free allocate and lowest-match retire
module csr_pending_cam
  import ctrl_scoreboard_pkg::*;
#(
  parameter int CSR_SLOTS      = DEF_CSR_SLOTS,
  parameter int CSR_ADDR_WIDTH = core_pkg::CSR_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      flush_i,
  input  logic [CSR_ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                      hit_o,
  output logic                      full_o,
  output logic                      busy_o,
  input  logic                      alloc_i,
  input  logic [CSR_ADDR_WIDTH-1:0] alloc_addr_i,
  input  logic                      retire_i,
  input  logic [CSR_ADDR_WIDTH-1:0] retire_addr_i,
  output logic                      retire_miss_o
);
  csr_slot_t [CSR_SLOTS-1:0] r_slot;
  logic [CSR_SLOTS-1:0] w_free_oh, w_ret_oh, w_hit, w_valid;
  // Descending scan so the last write wins, leaving the lowest index selected
  always_comb begin
    w_free_oh = '0;
    w_ret_oh  = '0;
    w_hit     = '0;
    w_valid   = '0;
    for (int i = CSR_SLOTS - 1; i >= 0; i--) begin
      w_valid[i] = r_slot[i].valid;
      w_hit[i]   = r_slot[i].valid && r_slot[i].addr == lookup_addr_i;
      if (!r_slot[i].valid) w_free_oh = CSR_SLOTS'(1) << i;
      if (r_slot[i].valid && r_slot[i].addr == retire_addr_i) w_ret_oh = CSR_SLOTS'(1) << i;
    end
  end
  assign hit_o         = |w_hit;
  assign full_o        = ~|w_free_oh;
  assign busy_o        = |w_valid;
  assign retire_miss_o = retire_i && ~|w_ret_oh;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_slot <= '0;
    else if (flush_i) r_slot <= '0;
    else begin
      for (int i = 0; i < CSR_SLOTS; i++) begin
        if (retire_i && w_ret_oh[i]) r_slot[i].valid <= 1'b0;
        if (alloc_i && w_free_oh[i]) r_slot[i] <= '{valid: 1'b1, addr: alloc_addr_i};
      end
    end
  end
endmodule

// File: rtl/ctrl_scoreboard.sv
// ctrl_scoreboard: RAW/WAW hazard tracker with per-register in-flight counters and pending CSR writes
module ctrl_scoreboard
  import core_pkg::*;
  import ctrl_scoreboard_pkg::*;
#(
  parameter int NB_RS        = DEF_NB_RS,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int CSR_SLOTS    = DEF_CSR_SLOTS
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           dec_valid_i,
  input  logic [NB_RS*RF_ADDR_WIDTH-1:0] dec_rs_i,
  input  logic [NB_RS-1:0]               dec_rs_used_i,
  input  logic [CSR_ADDR_WIDTH-1:0]      dec_csr_raddr_i,
  input  logic                           dec_csr_read_i,
  input  logic [RF_ADDR_WIDTH-1:0]       dec_rd_i,
  input  logic                           dec_rd_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0]      dec_csr_waddr_i,
  input  logic                           dec_csr_we_i,
  output logic                           issue_ready_o,
  input  logic                           wb_rd_valid_i,
  input  logic [RF_ADDR_WIDTH-1:0]       wb_rd_i,
  input  logic                           wb_csr_valid_i,
  input  logic [CSR_ADDR_WIDTH-1:0]      wb_csr_waddr_i,
  input  logic                           flush_i,
  output logic                           busy_o,
  output logic                           err_o
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int NREG  = 1 << RF_ADDR_WIDTH;
  logic [CNT_W-1:0] r_cnt [NREG];
  logic r_err;
  logic w_rs_haz, w_rd_sat, w_cnt_busy, w_wb_err, w_issue;
  logic w_csr_hit, w_csr_full, w_csr_busy, w_csr_miss;
  logic [NREG-1:0] w_inc, w_dec;
  always_comb begin
    w_rs_haz   = 1'b0;
    w_cnt_busy = 1'b0;
    for (int k = 0; k < NB_RS; k++)
      w_rs_haz = w_rs_haz | (dec_rs_used_i[k] && dec_rs_i[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] != '0
                             && r_cnt[dec_rs_i[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]] != '0);
    for (int i = 0; i < NREG; i++) w_cnt_busy = w_cnt_busy | (r_cnt[i] != '0);
  end
  assign w_rd_sat      = dec_rd_we_i && dec_rd_i != '0 && r_cnt[dec_rd_i] == CNT_W'(MAX_INFLIGHT);
  assign issue_ready_o = !(w_rs_haz || w_rd_sat || (dec_csr_read_i && w_csr_hit) || (dec_csr_we_i && w_csr_full));
  assign w_issue       = dec_valid_i && issue_ready_o;
  assign w_wb_err      = wb_rd_valid_i && wb_rd_i != '0 && r_cnt[wb_rd_i] == '0;
  // x0 never gets a strobe; an erroneous writeback leaves its counter untouched
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issue && dec_rd_we_i && dec_rd_i != '0) w_inc[dec_rd_i] = 1'b1;
    if (wb_rd_valid_i && wb_rd_i != '0 && !w_wb_err) w_dec[wb_rd_i] = 1'b1;
  end
  csr_pending_cam #(.CSR_SLOTS(CSR_SLOTS), .CSR_ADDR_WIDTH(CSR_ADDR_WIDTH)) u_cam (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .flush_i       (flush_i),
    .lookup_addr_i (dec_csr_raddr_i),
    .hit_o         (w_csr_hit),
    .full_o        (w_csr_full),
    .busy_o        (w_csr_busy),
    .alloc_i       (w_issue && dec_csr_we_i),
    .alloc_addr_i  (dec_csr_waddr_i),
    .retire_i      (wb_csr_valid_i),
    .retire_addr_i (wb_csr_waddr_i),
    .retire_miss_o (w_csr_miss)
  );
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        r_cnt[i] <= flush_i ? '0 : r_cnt[i] + CNT_W'(w_inc[i]) - CNT_W'(w_dec[i]);
      r_err <= r_err || (!flush_i && (w_wb_err || w_csr_miss));
    end
  end
  assign busy_o = w_cnt_busy || w_csr_busy;
  assign err_o  = r_err;
endmodule

// File: tb/tb_ctrl_scoreboard.sv
// tb_ctrl_scoreboard: scoreboard-driven bench for ctrl_scoreboard hazard tracking
module tb_ctrl_scoreboard;
  logic clk = 1'b0;
  logic rstn_i, dec_valid_i, dec_csr_read_i, dec_rd_we_i, dec_csr_we_i, issue_ready_o;
  logic [9:0] dec_rs_i;
  logic [1:0] dec_rs_used_i;
  logic [11:0] dec_csr_raddr_i, dec_csr_waddr_i, wb_csr_waddr_i;
  logic [4:0] dec_rd_i, wb_rd_i;
  logic wb_rd_valid_i, wb_csr_valid_i, flush_i, busy_o, err_o;

  ctrl_scoreboard dut (
    .clk_i(clk), .rstn_i(rstn_i), .dec_valid_i(dec_valid_i), .dec_rs_i(dec_rs_i),
    .dec_rs_used_i(dec_rs_used_i), .dec_csr_raddr_i(dec_csr_raddr_i), .dec_csr_read_i(dec_csr_read_i),
    .dec_rd_i(dec_rd_i), .dec_rd_we_i(dec_rd_we_i), .dec_csr_waddr_i(dec_csr_waddr_i),
    .dec_csr_we_i(dec_csr_we_i), .issue_ready_o(issue_ready_o), .wb_rd_valid_i(wb_rd_valid_i),
    .wb_rd_i(wb_rd_i), .wb_csr_valid_i(wb_csr_valid_i), .wb_csr_waddr_i(wb_csr_waddr_i),
    .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic ready; logic busy; logic err; string tag;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int want;
  int m_cnt[32];
  logic m_sv[2];
  logic [11:0] m_sa[2];
  logic m_err;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    for (int i = 0; i < 2; i++) begin m_sv[i] = 1'b0; m_sa[i] = '0; end
    m_err = 1'b0;
  endtask

  function automatic logic m_ready();
    logic r;
    r = 1'b1;
    if (dec_rs_used_i[0] && dec_rs_i[4:0] != 0 && m_cnt[dec_rs_i[4:0]] != 0) r = 1'b0;
    if (dec_rs_used_i[1] && dec_rs_i[9:5] != 0 && m_cnt[dec_rs_i[9:5]] != 0) r = 1'b0;
    if (dec_rd_we_i && dec_rd_i != 0 && m_cnt[dec_rd_i] == 3) r = 1'b0;
    if (dec_csr_read_i && ((m_sv[0] && m_sa[0] == dec_csr_raddr_i) || (m_sv[1] && m_sa[1] == dec_csr_raddr_i))) r = 1'b0;
    if (dec_csr_we_i && m_sv[0] && m_sv[1]) r = 1'b0;
    return r;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = m_sv[0] || m_sv[1];
    for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic m_update();
    logic rdy;
    int aa, ra;
    rdy = m_ready();
    aa = -1;
    ra = -1;
    if (flush_i) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_sv[0] = 1'b0;
      m_sv[1] = 1'b0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (aa < 0 && !m_sv[i]) aa = i;
      if (ra < 0 && m_sv[i] && m_sa[i] == wb_csr_waddr_i) ra = i;
    end
    if (wb_rd_valid_i && wb_rd_i != 0) begin
      if (m_cnt[wb_rd_i] == 0) m_err = 1'b1;
      else m_cnt[wb_rd_i]--;
    end
    if (dec_valid_i && rdy && dec_rd_we_i && dec_rd_i != 0) m_cnt[dec_rd_i]++;
    if (wb_csr_valid_i) begin
      if (ra < 0) m_err = 1'b1;
      else m_sv[ra] = 1'b0;
    end
    if (dec_valid_i && rdy && dec_csr_we_i && aa >= 0) begin
      m_sv[aa] = 1'b1;
      m_sa[aa] = dec_csr_waddr_i;
    end
  endtask

  task automatic clear_in();
    dec_valid_i = 0; dec_rs_i = '0; dec_rs_used_i = '0; dec_csr_raddr_i = '0; dec_csr_read_i = 0;
    dec_rd_i = '0; dec_rd_we_i = 0; dec_csr_waddr_i = '0; dec_csr_we_i = 0;
    wb_rd_valid_i = 0; wb_rd_i = '0; wb_csr_valid_i = 0; wb_csr_waddr_i = '0; flush_i = 0;
    want = -1;
  endtask

  task automatic present(input string tag);
    q.push_back('{ready: m_ready(), busy: m_busy(), err: m_err, tag: tag});
  endtask

  task automatic advance();
    m_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    dec_valid_i = 1; dec_rd_i = rd; dec_rd_we_i = 1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    clear_in();
    m_reset();
    #3;
    checks++;
    if ({issue_ready_o, busy_o, err_o} !== 3'b100) begin
      failures++;
      $display("FAIL reset rdy/busy/err got=%b%b%b exp=100", issue_ready_o, busy_o, err_o);
    end
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raw();
    for (int s = 0; s < 3; s++) begin
      clear_in();
      case (s)
        0: begin issue_rd(5); want = 1; end
        1: begin dec_valid_i = 1; dec_rs_i = {5'd0, 5'd5}; dec_rs_used_i = 2'b01; wb_rd_valid_i = 1; wb_rd_i = 5; want = 0; end
        default: begin dec_valid_i = 1; dec_rs_i = {5'd0, 5'd5}; dec_rs_used_i = 2'b01; want = 1; end
      endcase
      present($sformatf("raw[%0d]", s));
      #1;
      e = q.pop_front();
      checks++;
      if ({issue_ready_o, busy_o, err_o} !== {e.ready, e.busy, e.err}) begin
        failures++;
        $display("FAIL %s rdy/busy/err got=%b%b%b exp=%b%b%b", e.tag, issue_ready_o, busy_o, err_o, e.ready, e.busy, e.err);
      end
      if (want >= 0) begin
        checks++;
        if (issue_ready_o !== 1'(want)) begin failures++; $display("FAIL %s ready got=%b exp=%0d", e.tag, issue_ready_o, want); end
      end
      advance();
    end
  endtask

  task automatic test_x0_unused();
    for (int s = 0; s < 5; s++) begin
      clear_in();
      case (s)
        0: begin issue_rd(0); want = 1; end
        1: begin issue_rd(7); want = 1; end
        2: begin dec_valid_i = 1; dec_rs_i = {5'd7, 5'd0}; dec_rs_used_i = 2'b01; want = 1; end
        3: begin dec_valid_i = 1; dec_rs_i = {5'd7, 5'd0}; dec_rs_used_i = 2'b10; wb_rd_valid_i = 1; wb_rd_i = 7; want = 0; end
        default: want = 1;
      endcase
      present($sformatf("x0[%0d]", s));
      #1;
      e = q.pop_front();
      checks++;
      if ({issue_ready_o, busy_o, err_o} !== {e.ready, e.busy, e.err}) begin
        failures++;
        $display("FAIL %s rdy/busy/err got=%b%b%b exp=%b%b%b", e.tag, issue_ready_o, busy_o, err_o, e.ready, e.busy, e.err);
      end
      if (want >= 0) begin
        checks++;
        if (issue_ready_o !== 1'(want)) begin failures++; $display("FAIL %s ready got=%b exp=%0d", e.tag, issue_ready_o, want); end
      end
      advance();
    end
  endtask

  task automatic test_waw();
    for (int s = 0; s < 15; s++) begin
      clear_in();
      case (s)
        0, 1, 2: begin issue_rd(9); want = 1; end
        3: begin issue_rd(9); want = 0; end
        4: begin issue_rd(9); wb_rd_valid_i = 1; wb_rd_i = 9; want = 0; end
        5: begin issue_rd(9); want = 1; end
        6: begin issue_rd(9); want = 0; end
        7, 11, 12, 13: begin wb_rd_valid_i = 1; wb_rd_i = 9; want = 1; end
        8: begin issue_rd(9); wb_rd_valid_i = 1; wb_rd_i = 9; want = 1; end
        9: begin issue_rd(9); want = 1; end
        10: begin issue_rd(9); want = 0; end
        default: want = 1;
      endcase
      present($sformatf("waw[%0d]", s));
      #1;
      e = q.pop_front();
      checks++;
      if ({issue_ready_o, busy_o, err_o} !== {e.ready, e.busy, e.err}) begin
        failures++;
        $display("FAIL %s rdy/busy/err got=%b%b%b exp=%b%b%b", e.tag, issue_ready_o, busy_o, err_o, e.ready, e.busy, e.err);
      end
      if (want >= 0) begin
        checks++;
        if (issue_ready_o !== 1'(want)) begin failures++; $display("FAIL %s ready got=%b exp=%0d", e.tag, issue_ready_o, want); end
      end
      advance();
    end
  endtask

  task automatic test_csr();
    for (int s = 0; s < 14; s++) begin
      clear_in();
      dec_valid_i = 1;
      case (s)
        0: begin dec_csr_we_i = 1; dec_csr_waddr_i = 12'h300; want = 1; end
        1: begin dec_csr_we_i = 1; dec_csr_waddr_i = 12'h305; want = 1; end
        2: begin dec_csr_we_i = 1; dec_csr_waddr_i = 12'h310; want = 0; end
        3: begin dec_csr_read_i = 1; dec_csr_raddr_i = 12'h300; want = 0; end
        4: begin dec_csr_read_i = 1; dec_csr_raddr_i = 12'h300; wb_csr_valid_i = 1; wb_csr_waddr_i = 12'h300; want = 0; end
        5: begin dec_csr_read_i = 1; dec_csr_raddr_i = 12'h300; dec_csr_we_i = 1; dec_csr_waddr_i = 12'h310; want = 1; end
        6: begin dec_valid_i = 0; wb_csr_valid_i = 1; wb_csr_waddr_i = 12'h305; want = 1; end
        7: begin dec_csr_we_i = 1; dec_csr_waddr_i = 12'h320; wb_csr_valid_i = 1; wb_csr_waddr_i = 12'h310; want = 1; end
        8: begin dec_csr_read_i = 1; dec_csr_raddr_i = 12'h320; want = 0; end
        9: begin dec_csr_read_i = 1; dec_csr_raddr_i = 12'h310; dec_csr_we_i = 1; dec_csr_waddr_i = 12'h330; want = 1; end
        10: begin dec_csr_we_i = 1; dec_csr_waddr_i = 12'h340; want = 0; end
        11: begin dec_valid_i = 0; wb_csr_valid_i = 1; wb_csr_waddr_i = 12'h320; want = 1; end
        12: begin dec_valid_i = 0; wb_csr_valid_i = 1; wb_csr_waddr_i = 12'h330; want = 1; end
        default: begin dec_valid_i = 0; want = 1; end
      endcase
      present($sformatf("csr[%0d]", s));
      #1;
      e = q.pop_front();
      checks++;
      if ({issue_ready_o, busy_o, err_o} !== {e.ready, e.busy, e.err}) begin
        failures++;
        $display("FAIL %s rdy/busy/err got=%b%b%b exp=%b%b%b", e.tag, issue_ready_o, busy_o, err_o, e.ready, e.busy, e.err);
      end
      if (want >= 0) begin
        checks++;
        if (issue_ready_o !== 1'(want)) begin failures++; $display("FAIL %s ready got=%b exp=%0d", e.tag, issue_ready_o, want); end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int s = 0; s < 5; s++) begin
      clear_in();
      case (s)
        0, 1: begin issue_rd(3); want = 1; end
        2: begin dec_valid_i = 1; dec_csr_we_i = 1; dec_csr_waddr_i = 12'h341; want = 1; end
        3: begin issue_rd(4); flush_i = 1; want = 1; end
        default: begin dec_valid_i = 1; dec_rs_i = {5'd3, 5'd4}; dec_rs_used_i = 2'b11; dec_csr_read_i = 1; dec_csr_raddr_i = 12'h341; want = 1; end
      endcase
      present($sformatf("flush[%0d]", s));
      #1;
      e = q.pop_front();
      checks++;
      if ({issue_ready_o, busy_o, err_o} !== {e.ready, e.busy, e.err}) begin
        failures++;
        $display("FAIL %s rdy/busy/err got=%b%b%b exp=%b%b%b", e.tag, issue_ready_o, busy_o, err_o, e.ready, e.busy, e.err);
      end
      if (s == 4) begin
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL %s busy got=%b exp=0", e.tag, busy_o); end
      end
      if (want >= 0) begin
        checks++;
        if (issue_ready_o !== 1'(want)) begin failures++; $display("FAIL %s ready got=%b exp=%0d", e.tag, issue_ready_o, want); end
      end
      advance();
    end
  endtask

  task automatic test_error_reset();
    for (int s = 0; s < 7; s++) begin
      clear_in();
      case (s)
        0: begin wb_rd_valid_i = 1; wb_rd_i = 12; want = 1; end
        1: begin flush_i = 1; want = 1; end
        2: begin issue_rd(6); dec_csr_we_i = 1; dec_csr_waddr_i = 12'h300; want = 1; end
        3: begin
          rstn_i = 1'b0;
          #1;
          checks++;
          if ({issue_ready_o, busy_o, err_o} !== 3'b100) begin
            failures++;
            $display("FAIL mid_reset rdy/busy/err got=%b%b%b exp=100", issue_ready_o, busy_o, err_o);
          end
          m_reset();
          @(negedge clk);
          rstn_i = 1'b1;
          want = 1;
        end
        4: begin wb_csr_valid_i = 1; wb_csr_waddr_i = 12'h123; want = 1; end
        5: begin dec_valid_i = 1; dec_rs_i = {5'd0, 5'd6}; dec_rs_used_i = 2'b01; dec_csr_read_i = 1; dec_csr_raddr_i = 12'h300; want = 1; end
        default: want = 1;
      endcase
      present($sformatf("err[%0d]", s));
      #1;
      e = q.pop_front();
      checks++;
      if ({issue_ready_o, busy_o, err_o} !== {e.ready, e.busy, e.err}) begin
        failures++;
        $display("FAIL %s rdy/busy/err got=%b%b%b exp=%b%b%b", e.tag, issue_ready_o, busy_o, err_o, e.ready, e.busy, e.err);
      end
      if (s == 1 || s == 2 || s == 5) begin
        checks++;
        if (err_o !== 1'(s != 3 && s != 4)) begin failures++; $display("FAIL %s err got=%b exp=1", e.tag, err_o); end
      end
      if (want >= 0) begin
        checks++;
        if (issue_ready_o !== 1'(want)) begin failures++; $display("FAIL %s ready got=%b exp=%0d", e.tag, issue_ready_o, want); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0_unused();
    test_waw();
    test_csr();
    test_flush();
    test_error_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ctrl_scoreboard.md
Name: ctrl_scoreboard

Overview:
- Pipeline-controller hazard tracker. Consumes the IF pre-decode (source register indices, CSR read address) plus the destination fields of each issuing instruction.
- Keeps per-register in-flight write counters and a small pending-CSR-write table.
- Drives issue_ready_o to stall RAW/WAW hazards until writeback.
- Generalises the fixed two-source, single-CSR IF→CTRL payload to NB_RS sources, multiple in-flight writes per register and multiple pending CSR writes.

Parameters:
- RF_ADDR_WIDTH, 5, register index width (x0 never tracked).
- CSR_ADDR_WIDTH, 12, CSR address width.
- NB_RS, 2, source operands per instruction (2 or 3).
- MAX_INFLIGHT, 3, maximum outstanding writes to one register; counter width CNT_W = $clog2(MAX_INFLIGHT+1).
- CSR_SLOTS, 2, pending-CSR-write table entries.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- dec_valid_i  in  1  pre-decoded instruction presented.
- dec_rs_i  in  NB_RS*RF_ADDR_WIDTH  source indices, rs[k] at bits [k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH].
- dec_rs_used_i  in  NB_RS  per-source use flag.
- dec_csr_raddr_i  in  CSR_ADDR_WIDTH  CSR read address.
- dec_csr_read_i  in  1  instruction reads a CSR.
- dec_rd_i  in  RF_ADDR_WIDTH  destination register.
- dec_rd_we_i  in  1  instruction writes rd.
- dec_csr_waddr_i  in  CSR_ADDR_WIDTH  CSR write address.
- dec_csr_we_i  in  1  instruction writes a CSR.
- issue_ready_o  out  1  no hazard and capacity available; issue = dec_valid_i && issue_ready_o.
- wb_rd_valid_i  in  1  a register write retires this cycle.
- wb_rd_i  in  RF_ADDR_WIDTH  retiring register.
- wb_csr_valid_i  in  1  a CSR write retires this cycle.
- wb_csr_waddr_i  in  CSR_ADDR_WIDTH  retiring CSR address.
- flush_i  in  1  discard all tracking (branch/trap).
- busy_o  out  1  any counter non-zero or any CSR slot valid.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rstn_i=0):
  - All counters 0, all CSR slots invalid, err_o=0.
  - busy_o=0. issue_ready_o=1 for any input not hazarding against empty state.
- issue_ready_o:
  - Combinational from registered state and dec_* only; independent of dec_valid_i, wb_* and flush_i.
  - No same-cycle writeback bypass: a hazard clears the cycle after its writeback.
- issue_ready_o=0 when any of:
  - any k with dec_rs_used_i[k] && rs[k]!=0 && cnt[rs[k]]!=0;
  - dec_rd_we_i && dec_rd_i!=0 && cnt[dec_rd_i]==MAX_INFLIGHT;
  - dec_csr_read_i && a valid slot holds dec_csr_raddr_i;
  - dec_csr_we_i && no free slot.
- Issue (registered):
  - If dec_rd_we_i && rd!=0: cnt[rd]+1.
  - If dec_csr_we_i: allocate the lowest-index free slot with {valid=1, addr}.
  - rd==0 is never counted.
- Writeback (registered):
  - wb_rd_valid_i && wb_rd_i!=0: cnt[wb_rd_i]-1.
  - wb_csr_valid_i: invalidate the lowest-index valid slot matching wb_csr_waddr_i.
- Same-cycle issue and writeback to the same rd: net count unchanged.
- Same-cycle CSR issue and CSR retire:
  - The retire frees its slot first.
  - Allocation uses the free set computed before retire, so the freed slot is not reused this cycle.
- Protocol errors set err_o=1 until reset; the state is left unchanged:
  - writeback to a register whose counter is 0;
  - CSR retire matching no valid slot.
- flush_i=1: next cycle all counters 0 and all slots invalid. Same-cycle issue and writeback are ignored. err_o is kept.
- busy_o is registered-state derived and reflects the state after each clock edge.

Decomposition:
- Constants: RF_ADDR_WIDTH and CSR_ADDR_WIDTH come from core_pkg.
- Package ctrl_scoreboard_pkg holds:
  - the default NB_RS, MAX_INFLIGHT and CSR_SLOTS;
  - the typedef csr_slot_t {valid, addr}.
- Sub-module csr_pending_cam (CSR_SLOTS, CSR_ADDR_WIDTH). It provides match/free lookup, lowest-free allocate and lowest-match retire.
- The register counter array stays in ctrl_scoreboard.

Test Plan:
- RAW stall:
  - Issue rd=5 we; next cycle present rs1=5 used → issue_ready_o=0.
  - wb_rd_i=5 → issue_ready_o=1 one cycle later, not the same cycle.
- x0 and unused sources:
  - Issue rd=0 we → busy_o stays 0.
  - rs2=7 with dec_rs_used_i[1]=0 and cnt[7]=1 → issue_ready_o=1.
- WAW saturation (MAX_INFLIGHT=3):
  - Issue rd=9 three times → fourth rd=9 stalls.
  - One wb rd=9 → issue accepted; cnt[9] returns to 3.
  - Simultaneous issue+wb on rd=9 keeps cnt[9]=3.
- CSR table (CSR_SLOTS=2):
  - Write 0x300 then 0x305 → third CSR write stalls; read of 0x300 stalls.
  - Retire 0x300 → read of 0x300 and a new write accepted next cycle.
- Flush:
  - With cnt[3]=2 and one CSR slot valid, assert flush_i together with an issue rd=4 → next cycle busy_o=0 and cnt[4]=0.
- Error and reset:
  - wb rd=12 with cnt[12]=0 → err_o=1, persists across flush.
  - rstn_i low mid-operation → all outputs at reset values immediately, err_o=0.
